// File: rtl/flip_match_if.sv
// flip_match_if: shuffle, selection and display signals of the Card-Flip game controller
interface flip_match_if;
  logic        new_game;
  logic        shuffle_start;
  logic [0:47] map;
  logic        map_done;
  logic [3:0]  sel_idx;
  logic        sel_valid;
  logic [15:0] face_up;
  logic [15:0] matched;
  logic [0:47] card_vals;
  logic [3:0]  pairs;
  logic [7:0]  moves;
  logic        busy;
  logic        win;
  logic        lose;
  modport master (
    output new_game, map, map_done, sel_idx, sel_valid,
    input  shuffle_start, face_up, matched, card_vals, pairs, moves, busy, win, lose
  );
  modport slave (
    input  new_game, map, map_done, sel_idx, sel_valid,
    output shuffle_start, face_up, matched, card_vals, pairs, moves, busy, win, lose
  );
endinterface

// File: rtl/flip_match_ctrl.sv
// flip_match_ctrl: Card-Flip game controller; define MOVE_LIMIT_EN to enable the MAX_MOVES lose condition
module flip_match_ctrl #(
  parameter int         HOLD_CYCLES = 50_000_000,
  parameter logic [7:0] MAX_MOVES   = 8'd32
) (
  input logic         clk,
  input logic         reset,
  flip_match_if.slave bus
);
`ifdef MOVE_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif
  localparam int CW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
  typedef enum logic [2:0] {IDLE, LOAD, PICK1, PICK2, COMPARE, HOLD, WIN, LOSE} state_t;
  state_t        state, state_n;
  logic [15:0]   face_up, face_n, matched, matched_n;
  logic [0:47]   vals, vals_n;
  logic [3:0]    pairs, pairs_n, first, first_n, second, second_n;
  logic [7:0]    moves, moves_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          start, start_n, legal;
  logic [2:0]    v1, v2;
  assign legal = bus.sel_valid && !face_up[bus.sel_idx] && !matched[bus.sel_idx];
  assign v1 = vals[first*3 +: 3];
  assign v2 = vals[second*3 +: 3];
  // next-state and datapath update; new_game overrides everything except reset
  always_comb begin
    state_n   = state;
    face_n    = face_up;
    matched_n = matched;
    vals_n    = vals;
    pairs_n   = pairs;
    first_n   = first;
    second_n  = second;
    moves_n   = moves;
    cnt_n     = cnt;
    start_n   = 1'b0;
    if (bus.new_game) begin
      state_n   = LOAD;
      start_n   = 1'b1;
      face_n    = '0;
      matched_n = '0;
      pairs_n   = '0;
      moves_n   = '0;
    end else begin
      case (state)
        LOAD: if (bus.map_done) begin
          vals_n  = bus.map;
          state_n = PICK1;
        end
        PICK1: if (legal) begin
          face_n[bus.sel_idx] = 1'b1;
          first_n = bus.sel_idx;
          state_n = PICK2;
        end
        PICK2: if (legal && bus.sel_idx != first) begin
          face_n[bus.sel_idx] = 1'b1;
          second_n = bus.sel_idx;
          moves_n  = moves == 8'hFF ? moves : moves + 8'd1;
          state_n  = COMPARE;
        end
        COMPARE: if (v1 == v2) begin
          matched_n[first]  = 1'b1;
          matched_n[second] = 1'b1;
          pairs_n = pairs + 4'd1;
          state_n = pairs == 4'd7 ? WIN : PICK1;
        end else if (LIMIT_EN && moves == MAX_MOVES) begin
          state_n = LOSE;
        end else begin
          cnt_n   = CW'(HOLD_CYCLES - 1);
          state_n = HOLD;
        end
        HOLD: if (cnt == '0) begin
          face_n[first]  = 1'b0;
          face_n[second] = 1'b0;
          state_n = PICK1;
        end else begin
          cnt_n = cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end
  // state and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      face_up <= '0;
      matched <= '0;
      vals    <= '0;
      pairs   <= '0;
      first   <= '0;
      second  <= '0;
      moves   <= '0;
      cnt     <= '0;
      start   <= 1'b0;
    end else begin
      state   <= state_n;
      face_up <= face_n;
      matched <= matched_n;
      vals    <= vals_n;
      pairs   <= pairs_n;
      first   <= first_n;
      second  <= second_n;
      moves   <= moves_n;
      cnt     <= cnt_n;
      start   <= start_n;
    end
  end
  assign bus.shuffle_start = start;
  assign bus.face_up       = face_up;
  assign bus.matched       = matched;
  assign bus.card_vals     = vals;
  assign bus.pairs         = pairs;
  assign bus.moves         = moves;
  assign bus.busy          = state == LOAD || state == COMPARE || state == HOLD;
  assign bus.win           = state == WIN;
  assign bus.lose          = LIMIT_EN && state == LOSE;
endmodule

// File: tb/tb_flip_match_ctrl.sv
// tb_flip_match_ctrl: table-driven check of flip_match_ctrl with HOLD_CYCLES=4, MAX_MOVES=2
module tb_flip_match_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  flip_match_if bus();
  flip_match_ctrl #(.HOLD_CYCLES(4), .MAX_MOVES(8'd2)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic        ng, md, sv;
    logic [3:0]  idx;
    logic [15:0] fu, mt;
    logic [3:0]  pr;
    logic [7:0]  mv;
    logic        bz, win, ss;
  } vec_t;
  vec_t vecs[$];
  int card_v[16] = '{6, 0, 0, 1, 1, 6, 2, 2, 3, 3, 4, 4, 5, 5, 7, 7};
  int pa[6] = '{3, 6, 8, 10, 12, 14};
  logic [0:47] map_v;
  logic [15:0] f, m;
  int pr, mv;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic push(input logic ng, md, sv, input logic [3:0] idx, input logic [15:0] fu, mt,
                      input logic [3:0] p, input logic [7:0] v, input logic bz, w, ss);
    vecs.push_back('{ng, md, sv, idx, fu, mt, p, v, bz, w, ss});
  endtask
  task automatic cyc(input logic ng, md, sv, input logic [3:0] idx);
    @(negedge clk);
    bus.new_game = ng;
    bus.map_done = md;
    bus.sel_valid = sv;
    bus.sel_idx = idx;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, " face_up"}, 64'(bus.face_up), 64'h0);
    chk({tag, " matched"}, 64'(bus.matched), 64'h0);
    chk({tag, " card_vals"}, 64'(bus.card_vals), 64'h0);
    chk({tag, " pairs"}, 64'(bus.pairs), 64'h0);
    chk({tag, " moves"}, 64'(bus.moves), 64'h0);
    chk({tag, " shuffle_start"}, 64'(bus.shuffle_start), 64'h0);
    chk({tag, " busy"}, 64'(bus.busy), 64'h0);
    chk({tag, " win"}, 64'(bus.win), 64'h0);
    chk({tag, " lose"}, 64'(bus.lose), 64'h0);
  endtask
  initial begin
    for (int i = 0; i < 16; i++) map_v[3*i +: 3] = 3'(card_v[i]);
    bus.map = map_v;
    bus.new_game = 1'b0;
    bus.map_done = 1'b0;
    bus.sel_valid = 1'b0;
    bus.sel_idx = 4'd0;
    push(1, 0, 0, 0,  16'h0000, 16'h0000, 0, 0, 1, 0, 1);
    push(0, 0, 0, 0,  16'h0000, 16'h0000, 0, 0, 1, 0, 0);
    push(0, 0, 1, 3,  16'h0000, 16'h0000, 0, 0, 1, 0, 0);
    push(0, 1, 0, 0,  16'h0000, 16'h0000, 0, 0, 0, 0, 0);
    push(0, 0, 1, 0,  16'h0001, 16'h0000, 0, 0, 0, 0, 0);
    push(0, 0, 1, 0,  16'h0001, 16'h0000, 0, 0, 0, 0, 0);
    push(0, 0, 1, 5,  16'h0021, 16'h0000, 0, 1, 1, 0, 0);
    push(0, 0, 0, 0,  16'h0021, 16'h0021, 1, 1, 0, 0, 0);
    push(0, 0, 1, 5,  16'h0021, 16'h0021, 1, 1, 0, 0, 0);
    push(0, 0, 1, 1,  16'h0023, 16'h0021, 1, 1, 0, 0, 0);
    push(0, 0, 1, 2,  16'h0027, 16'h0021, 1, 2, 1, 0, 0);
    push(0, 0, 0, 0,  16'h0027, 16'h0027, 2, 2, 0, 0, 0);
    push(0, 0, 1, 3,  16'h002F, 16'h0027, 2, 2, 0, 0, 0);
    push(0, 0, 1, 6,  16'h006F, 16'h0027, 2, 3, 1, 0, 0);
    push(0, 0, 0, 0,  16'h006F, 16'h0027, 2, 3, 1, 0, 0);
    push(0, 0, 1, 7,  16'h006F, 16'h0027, 2, 3, 1, 0, 0);
    push(0, 0, 0, 0,  16'h006F, 16'h0027, 2, 3, 1, 0, 0);
    push(0, 0, 0, 0,  16'h006F, 16'h0027, 2, 3, 1, 0, 0);
    push(0, 0, 0, 0,  16'h0027, 16'h0027, 2, 3, 0, 0, 0);
    f = 16'h0027;
    m = 16'h0027;
    pr = 2;
    mv = 3;
    for (int k = 0; k < 6; k++) begin
      f |= 16'h1 << pa[k];
      push(0, 0, 1, 4'(pa[k]), f, m, 4'(pr), 8'(mv), 0, 0, 0);
      f |= 16'h2 << pa[k];
      mv++;
      push(0, 0, 1, 4'(pa[k] + 1), f, m, 4'(pr), 8'(mv), 1, 0, 0);
      m |= 16'h3 << pa[k];
      pr++;
      push(0, 0, 0, 0, f, m, 4'(pr), 8'(mv), 0, pr == 8, 0);
    end
    push(0, 0, 1, 0,  16'hFFFF, 16'hFFFF, 8, 9, 0, 1, 0);
    push(1, 0, 0, 0,  16'h0000, 16'h0000, 0, 0, 1, 0, 1);
    push(0, 0, 0, 0,  16'h0000, 16'h0000, 0, 0, 1, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    reset = 1'b0;
    foreach (vecs[i]) begin
      cyc(vecs[i].ng, vecs[i].md, vecs[i].sv, vecs[i].idx);
      chk($sformatf("v%0d face_up", i), 64'(bus.face_up), 64'(vecs[i].fu));
      chk($sformatf("v%0d matched", i), 64'(bus.matched), 64'(vecs[i].mt));
      chk($sformatf("v%0d pairs", i), 64'(bus.pairs), 64'(vecs[i].pr));
      chk($sformatf("v%0d moves", i), 64'(bus.moves), 64'(vecs[i].mv));
      chk($sformatf("v%0d busy", i), 64'(bus.busy), 64'(vecs[i].bz));
      chk($sformatf("v%0d win", i), 64'(bus.win), 64'(vecs[i].win));
      chk($sformatf("v%0d shuffle_start", i), 64'(bus.shuffle_start), 64'(vecs[i].ss));
      chk($sformatf("v%0d lose", i), 64'(bus.lose), 64'h0);
      if (i == 3) begin
        chk("card0 value", 64'(bus.card_vals[0 +: 3]), 64'd6);
        chk("card_vals", 64'(bus.card_vals), 64'(map_v));
      end
    end
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 0, 0);
    chk("hold busy", 64'(bus.busy), 64'h1);
    chk("hold face_up", 64'(bus.face_up), 64'h0003);
    cyc(0, 0, 0, 0);
    reset = 1'b1;
    cyc(1, 0, 0, 0);
    chk_zero("mid-hold reset");
    reset = 1'b0;
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 1);
    repeat (5) cyc(0, 0, 0, 0);
    chk("limit first clear", 64'(bus.face_up), 64'h0);
    chk("limit first moves", 64'(bus.moves), 64'd1);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 3);
    chk("limit second moves", 64'(bus.moves), 64'd2);
    cyc(0, 0, 1, 2);
    chk("limit face_up", 64'(bus.face_up), 64'h0009);
`ifdef MOVE_LIMIT_EN
    chk("limit lose", 64'(bus.lose), 64'h1);
    chk("limit busy", 64'(bus.busy), 64'h0);
`else
    chk("limit lose", 64'(bus.lose), 64'h0);
    chk("limit busy", 64'(bus.busy), 64'h1);
`endif
    cyc(1, 0, 0, 0);
    chk("restart lose", 64'(bus.lose), 64'h0);
    chk("restart shuffle_start", 64'(bus.shuffle_start), 64'h1);
    chk("restart face_up", 64'(bus.face_up), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/flip_match_ctrl.md
# flip_match_ctrl

Game-play controller for Card-Flip, directly downstream of the shuffle stage. It requests a new shuffle, latches the 16-card value map (8 pairs of 3-bit values) when the shuffle reports done, and accepts card selections two at a time. It compares each pair, keeps matched cards face-up, hides mismatches after a display hold, counts moves and pairs, and flags the win. The display/VGA logic consumes its face-up, matched and value outputs.

## Interface
- HOLD_CYCLES, default 50_000_000: cycles a mismatched pair stays face-up (≥1).
- MAX_MOVES, default 8'd32: move limit, used only when MOVE_LIMIT_EN is defined.
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  one clock; reset is synchronous and active-high.
- new_game  in  1  pulse: abandon the current game and request a shuffle.
- shuffle_start  out  1  one-cycle pulse to the shuffle stage's start input.
- map  in  [0:47]  card values; card i = map[3*i +: 3], with map[3*i] as the MSB.
- map_done  in  1  one-cycle pulse from the shuffle stage; map is valid in that cycle.
- sel_idx  in  4  card index 0–15.
- sel_valid  in  1  one-cycle selection strobe.
- face_up  out  16  bit i = card i shown (includes matched cards).
- matched  out  16  bit i = card i permanently matched.
- card_vals  out  [0:47]  latched map.
- pairs  out  4  pairs found, 0–8.
- moves  out  8  completed two-card attempts; saturates at 255.
- busy  out  1  1 in LOAD, COMPARE, HOLD.
- win  out  1  level, 1 in WIN.
- lose  out  1  level, 1 in LOSE (tied 0 without MOVE_LIMIT_EN).

## Operation
- States: IDLE, LOAD, PICK1, PICK2, COMPARE, HOLD, WIN, LOSE.
- Reset → IDLE. All outputs are 0: face_up, matched, card_vals, pairs, moves, shuffle_start, busy, win, lose. first/second index registers and hold counter are also 0.
- new_game in any state (higher priority than every other input) → shuffle_start=1 next cycle. face_up, matched, pairs and moves clear, and state → LOAD.
- LOAD: wait for map_done. On map_done, latch card_vals←map and go → PICK1. map_done in any other state is ignored.
- PICK1: sel_valid with the card neither face-up nor matched → set face_up[sel_idx], store first index, go → PICK2. Invalid selections are ignored with no state change.
- PICK2: sel_valid with a legal card that differs from the first → set face_up, store second index, increment moves (saturating), go → COMPARE. Reselecting the first card or a face-up card is ignored.
- COMPARE (1 cycle), values equal → set both matched bits, pairs+1, next → WIN if the new pairs==8, else PICK1.
- COMPARE, values unequal → HOLD, with the counter loaded to HOLD_CYCLES-1.
- HOLD: count down. At 0, clear both face_up bits and go → PICK1. sel_valid is ignored throughout.
- WIN/LOSE: outputs hold; only new_game or reset leaves.
- sel_valid in IDLE, LOAD, COMPARE, HOLD, WIN or LOSE is dropped, not queued.

## Timing
- shuffle_start is high exactly 1 cycle, the cycle after new_game is sampled.
- map_done sampled at cycle t → card_vals valid and state PICK1 at t+1.
- First pick sampled at t → face_up bit visible at t+1.
- Second pick sampled at t → face_up and moves update at t+1 (COMPARE).
- Match result (matched, pairs, win) is visible at t+2.
- Mismatch: cards are face-up from t+1 through t+1+HOLD_CYCLES. The bits clear at t+2+HOLD_CYCLES.
- Reset mid-game or mid-HOLD has priority over new_game and returns to IDLE in 1 cycle with all outputs 0.

## Configuration
- MOVE_LIMIT_EN defined: in COMPARE, a mismatch with moves==MAX_MOVES goes → LOSE instead of HOLD. face_up is left as-is and lose=1.
- A match on the final allowed move still counts; WIN has priority over LOSE.
- MOVE_LIMIT_EN undefined: LOSE is unreachable, lose tied 0, and MAX_MOVES is unused.

## Test plan
- Reset, then new_game → shuffle_start high for exactly 1 cycle. Then map_done with card0=card5=3'd6 → state PICK1 and card_vals[0+:3]=3'd6.
- Pick 0 then 5 → face_up=16'h0021 after the second pick, matched=16'h0021 and pairs=1 one cycle later, moves=1.
- Pick 0 and 1 with different values, HOLD_CYCLES=4 → both bits up for 5 cycles then cleared, pairs=0, moves=1. A sel_valid during HOLD is ignored.
- Reselect the first card in PICK2, pick a matched card, pick during LOAD → no change to face_up or moves.
- Play all 8 pairs → pairs=8, win=1, matched=16'hFFFF. Then new_game → all cleared and shuffle_start pulses.
- With MOVE_LIMIT_EN and MAX_MOVES=2: two mismatches → lose=1 after the second COMPARE. Reset asserted mid-HOLD → all outputs 0 next cycle.
